// File: rtl/guess_game_core.sv
`default_nettype none
// ============================================================================
// Module      : guess_game_core
// Description : Number-guessing game. First committed keypad entry becomes the
//               secret; later entries are guesses compared against it.
// Revision    : 1.0 - initial release
// ============================================================================
module guess_game_core #(
    parameter int NUM_KEYS   = 4,
    parameter int MAX_DIGITS = 8,
    parameter int MAX_TRIES  = 3
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_KEYS-1:0]                keys,
    input  logic                               enter,
    output logic                               win,
    output logic                               lose,
    output logic                               equal,
    output logic                               bigger,
    output logic                               smaller,
    output logic [NUM_KEYS-1:0]                nums,
    output logic [$clog2(MAX_DIGITS+1)-1:0]    digit_cnt,
    output logic [$clog2(MAX_TRIES+1)-1:0]     tries_left,
    output logic                               busy_guess
);

    localparam int c_cnt_w = $clog2(MAX_DIGITS+1);
    localparam int c_try_w = $clog2(MAX_TRIES+1);
    localparam int c_dig_w = $clog2(NUM_KEYS+1);
    localparam int c_buf_w = c_dig_w * MAX_DIGITS;

    typedef enum logic [1:0] {
        ST_SET   = 2'd0,
        ST_GUESS = 2'd1,
        ST_WON   = 2'd2,
        ST_LOST  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_KEYS-1:0]  keys_q, keys_d, keys_prev_q, keys_prev_d;
    logic                 enter_q, enter_d, enter_prev_q, enter_prev_d;
    logic [c_buf_w-1:0]   buf_q, buf_d, secret_q, secret_d;
    logic [c_cnt_w-1:0]   cnt_q, cnt_d;
    logic [c_try_w-1:0]   tries_q, tries_d;
    logic [NUM_KEYS-1:0]  nums_q, nums_d;
    logic                 win_q, win_d, lose_q, lose_d;
    logic                 equal_q, equal_d, bigger_q, bigger_d, smaller_q, smaller_d;

    logic [NUM_KEYS-1:0]  key_rise;
    logic                 enter_rise;
    logic                 key_single;
    logic [c_dig_w-1:0]   key_digit;

    always_comb begin
        keys_d       = keys;
        keys_prev_d  = keys_q;
        enter_d      = enter;
        enter_prev_d = enter_q;
        state_d      = state_q;
        buf_d        = buf_q;
        secret_d     = secret_q;
        cnt_d        = cnt_q;
        tries_d      = tries_q;
        nums_d       = nums_q;
        win_d        = win_q;
        lose_d       = lose_q;
        equal_d      = equal_q;
        bigger_d     = bigger_q;
        smaller_d    = smaller_q;

        key_rise   = keys_q & ~keys_prev_q;
        enter_rise = enter_q & ~enter_prev_q;
        key_single = (key_rise != '0) && ((key_rise & (key_rise - 1'b1)) == '0);
        key_digit  = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (key_rise[k]) key_digit = c_dig_w'(k + 1);
        end

        // Digits are nonzero and shifted in at the LSB end, so the leading
        // zero fields make a plain unsigned compare order by length first.
        if (state_q == ST_SET || state_q == ST_GUESS) begin
            if (enter_rise) begin
                if (cnt_q != '0) begin
                    buf_d  = '0;
                    cnt_d  = '0;
                    nums_d = '0;
                    if (state_q == ST_SET) begin
                        secret_d = buf_q;
                        state_d  = ST_GUESS;
                    end else begin
                        equal_d   = (buf_q == secret_q);
                        bigger_d  = (buf_q >  secret_q);
                        smaller_d = (buf_q <  secret_q);
                        if (buf_q == secret_q) begin
                            win_d   = 1'b1;
                            state_d = ST_WON;
                        end else begin
                            tries_d = tries_q - 1'b1;
                            if (tries_q == c_try_w'(1)) begin
                                lose_d  = 1'b1;
                                state_d = ST_LOST;
                            end
                        end
                    end
                end
            end else if (key_single && (cnt_q < c_cnt_w'(MAX_DIGITS))) begin
                buf_d  = (buf_q << c_dig_w) | c_buf_w'(key_digit);
                cnt_d  = cnt_q + 1'b1;
                nums_d = key_rise;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_SET;
            keys_q       <= '0;
            keys_prev_q  <= '0;
            enter_q      <= 1'b0;
            enter_prev_q <= 1'b0;
            buf_q        <= '0;
            secret_q     <= '0;
            cnt_q        <= '0;
            tries_q      <= c_try_w'(MAX_TRIES);
            nums_q       <= '0;
            win_q        <= 1'b0;
            lose_q       <= 1'b0;
            equal_q      <= 1'b0;
            bigger_q     <= 1'b0;
            smaller_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            keys_q       <= keys_d;
            keys_prev_q  <= keys_prev_d;
            enter_q      <= enter_d;
            enter_prev_q <= enter_prev_d;
            buf_q        <= buf_d;
            secret_q     <= secret_d;
            cnt_q        <= cnt_d;
            tries_q      <= tries_d;
            nums_q       <= nums_d;
            win_q        <= win_d;
            lose_q       <= lose_d;
            equal_q      <= equal_d;
            bigger_q     <= bigger_d;
            smaller_q    <= smaller_d;
        end
    end

    assign win        = win_q;
    assign lose       = lose_q;
    assign equal      = equal_q;
    assign bigger     = bigger_q;
    assign smaller    = smaller_q;
    assign nums       = nums_q;
    assign digit_cnt  = cnt_q;
    assign tries_left = tries_q;
    assign busy_guess = (state_q != ST_SET);

endmodule
`default_nettype wire
